sfm_tcdm_slave_mem: RTL and testbench

//  Multi-port word-interleaved TCDM memory responder: the slave end of the MP x 32-bit TCDM master ports driven by the

---
 rtl/sfm_tcdm_slave_mem.sv | 121 ++++++++++++
 tb/tb_sfm_tcdm_slave_mem.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfm_tcdm_slave_mem.sv
// Multi-port word-interleaved TCDM responder: fixed-priority bank arbitration,
// LFSR stall injection, pipelined fixed-latency reads, backdoor write, counters.
module sfm_tcdm_slave_mem #(
  parameter int          MP        = 4,
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 1,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [MP-1:0]         tcdm_req_i,
  output logic [MP-1:0]         tcdm_gnt_o,
  input  logic [MP-1:0][31:0]   tcdm_add_i,
  input  logic [MP-1:0]         tcdm_wen_i,
  input  logic [MP-1:0][3:0]    tcdm_be_i,
  input  logic [MP-1:0][31:0]   tcdm_data_i,
  output logic [MP-1:0][31:0]   tcdm_r_data_o,
  output logic [MP-1:0]         tcdm_r_valid_o,
  input  logic                  bd_req_i,
  input  logic [31:0]           bd_add_i,
  input  logic [31:0]           bd_data_i,
  output logic [31:0]           n_reads_o,
  output logic [31:0]           n_writes_o,
  output logic [31:0]           n_conflicts_o
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (MP > 1) ? $clog2(MP) : 1;

  logic [31:0]                 mem [MEM_WORDS];
  logic [MP-1:0][AW-1:0]       widx;
  logic [MP-1:0][BW-1:0]       bank;
  logic [MP-1:0]               lose, rd, wr;
  logic [MP-1:0][31:0]         rd_word;
  logic [15:0]                 lfsr;
  logic                        stall;
  logic [AW-1:0]               bd_widx;
  logic [LATENCY-1:0][MP-1:0]        vld_pipe;
  logic [LATENCY-1:0][MP-1:0][31:0]  dat_pipe;
  logic                        unused_addr;

  assign unused_addr = ^{tcdm_add_i, bd_add_i};
  assign bd_widx     = bd_add_i[AW+1:2];
  assign stall       = (STALL_EN != 0) && (lfsr[1:0] == 2'b00);

  always_comb begin
    for (int i = 0; i < MP; i++) begin
      widx[i]    = tcdm_add_i[i][AW+1:2];
      bank[i]    = BW'(32'(widx[i]) % MP);
      rd_word[i] = mem[widx[i]];
    end
  end

  // Fixed priority: a port loses to any lower-index requester on the same bank.
  always_comb begin
    lose = '0;
    for (int i = 1; i < MP; i++)
      for (int j = 0; j < i; j++)
        if (tcdm_req_i[j] && (bank[j] == bank[i])) lose[i] = 1'b1;
  end

  assign tcdm_gnt_o = tcdm_req_i & ~lose & {MP{~stall & ~bd_req_i & rst_ni}};
  assign rd         = tcdm_gnt_o & tcdm_wen_i;
  assign wr         = tcdm_gnt_o & ~tcdm_wen_i;

  // Granted ports always hit distinct banks, and the backdoor blocks all ports,
  // so no two writers ever target the same word in one cycle.
  always_ff @(posedge clk_i) begin
    if (bd_req_i) mem[bd_widx] <= bd_data_i;
    for (int i = 0; i < MP; i++)
      if (wr[i])
        for (int b = 0; b < 4; b++)
          if (tcdm_be_i[i][b]) mem[widx[i]][8*b +: 8] <= tcdm_data_i[i][8*b +: 8];
  end

  // Data stages only load on a valid so the output holds between pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd;
      for (int i = 0; i < MP; i++)
        if (rd[i]) dat_pipe[0][i] <= rd_word[i];
      for (int s = 1; s < LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        for (int i = 0; i < MP; i++)
          if (vld_pipe[s-1][i]) dat_pipe[s][i] <= dat_pipe[s-1][i];
      end
    end
  end

  assign tcdm_r_valid_o = vld_pipe[LATENCY-1];
  assign tcdm_r_data_o  = dat_pipe[LATENCY-1];

  function automatic logic [31:0] popcnt(input logic [MP-1:0] v);
    popcnt = '0;
    for (int i = 0; i < MP; i++) popcnt = popcnt + 32'(v[i]);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr          <= LFSR_SEED;
      n_reads_o     <= '0;
      n_writes_o    <= '0;
      n_conflicts_o <= '0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      n_reads_o  <= sat_add(n_reads_o, popcnt(rd));
      n_writes_o <= sat_add(n_writes_o, popcnt(wr));
      if (|(tcdm_req_i & lose) && !stall)
        n_conflicts_o <= sat_add(n_conflicts_o, 32'd1);
    end
  end
endmodule

// File: tb/tb_sfm_tcdm_slave_mem.sv
// Bench for sfm_tcdm_slave_mem: two instances (latency 3 no stalls, latency 1
// with stalls) on shared stimulus, checked every cycle against a behavioural model.
module tb_sfm_tcdm_slave_mem;
  localparam int MP = 4;
  localparam int MW = 64;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int LAT [2] = '{3, 1};
  localparam int SEN [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic [MP-1:0]       req, wen;
  logic [MP-1:0][31:0] add, data;
  logic [MP-1:0][3:0]  be;
  logic                bd_req;
  logic [31:0]         bd_add, bd_data;

  logic [MP-1:0]       gnt [2];
  logic [MP-1:0]       rvld [2];
  logic [MP-1:0][31:0] rdat [2];
  logic [31:0]         nrd [2], nwr [2], ncf [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfm_tcdm_slave_mem #(.MP(MP), .MEM_WORDS(MW), .LATENCY(3), .STALL_EN(0), .LFSR_SEED(SEED)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(req), .tcdm_gnt_o(gnt[0]), .tcdm_add_i(add),
    .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(data), .tcdm_r_data_o(rdat[0]),
    .tcdm_r_valid_o(rvld[0]), .bd_req_i(bd_req), .bd_add_i(bd_add), .bd_data_i(bd_data),
    .n_reads_o(nrd[0]), .n_writes_o(nwr[0]), .n_conflicts_o(ncf[0]));

  sfm_tcdm_slave_mem #(.MP(MP), .MEM_WORDS(MW), .LATENCY(1), .STALL_EN(1), .LFSR_SEED(SEED)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tcdm_req_i(req), .tcdm_gnt_o(gnt[1]), .tcdm_add_i(add),
    .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(data), .tcdm_r_data_o(rdat[1]),
    .tcdm_r_valid_o(rvld[1]), .bd_req_i(bd_req), .bd_add_i(bd_add), .bd_data_i(bd_data),
    .n_reads_o(nrd[1]), .n_writes_o(nwr[1]), .n_conflicts_o(ncf[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Model: memory image, LFSR, counters and a response schedule keyed by cycle.
  logic [31:0] m_mem  [2][MW];
  logic [15:0] m_lfsr [2];
  logic [31:0] m_rd [2], m_wr [2], m_cf [2];
  bit          sv   [2][8][MP];
  logic [31:0] sd   [2][8][MP];
  logic [31:0] hold [2][MP];
  int          cyc = 0;

  always @(negedge clk) begin
    bit [MP-1:0] eg, ls, ev;
    bit          stl;
    int          slot, w;
    slot = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int s = 0; s < 8; s++)
          for (int p = 0; p < MP; p++) sv[k][s][p] = 1'b0;
        for (int p = 0; p < MP; p++) hold[k][p] = '0;
        m_lfsr[k] = SEED;
        m_rd[k] = '0; m_wr[k] = '0; m_cf[k] = '0;
      end
      ev = '0;
      for (int p = 0; p < MP; p++)
        if (sv[k][slot][p]) begin hold[k][p] = sd[k][slot][p]; ev[p] = 1'b1; end
      ls = '0;
      for (int i = 0; i < MP; i++)
        for (int j = 0; j < i; j++)
          if (req[j] && (word_of(add[j]) % MP) == (word_of(add[i]) % MP)) ls[i] = 1'b1;
      stl = (SEN[k] != 0) && (m_lfsr[k][1:0] == 2'b00);
      for (int i = 0; i < MP; i++) eg[i] = rst_n && req[i] && !ls[i] && !stl && !bd_req;

      chk($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg));
      chk($sformatf("rvalid%0d", k), 32'(rvld[k]), 32'(ev));
      for (int p = 0; p < MP; p++) chk($sformatf("rdata%0d_%0d", k, p), rdat[k][p], hold[k][p]);
      chk($sformatf("n_reads%0d", k), nrd[k], m_rd[k]);
      chk($sformatf("n_writes%0d", k), nwr[k], m_wr[k]);
      chk($sformatf("n_conflicts%0d", k), ncf[k], m_cf[k]);

      for (int p = 0; p < MP; p++) sv[k][slot][p] = 1'b0;
      if (rst_n) begin
        for (int i = 0; i < MP; i++)
          if (eg[i] && wen[i]) begin
            sv[k][(cyc + LAT[k]) % 8][i] = 1'b1;
            sd[k][(cyc + LAT[k]) % 8][i] = m_mem[k][word_of(add[i])];
          end
        for (int i = 0; i < MP; i++)
          if (eg[i] && !wen[i]) begin
            w = word_of(add[i]);
            for (int b = 0; b < 4; b++)
              if (be[i][b]) m_mem[k][w][8*b +: 8] = data[i][8*b +: 8];
          end
        m_rd[k] = m_rd[k] + $countones(eg & wen);
        m_wr[k] = m_wr[k] + $countones(eg & ~wen);
        if (|(req & ls) && !stl) m_cf[k] = m_cf[k] + 1;
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
      end
      if (bd_req) m_mem[k][word_of(bd_add)] = bd_data;
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  logic [31:0] exp5 [8];
  bit          pat6 [6];

  initial begin
    exp5 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             32'h00AD00EF, 32'h0, 32'h0, 32'h0};
    // LFSR from 0xACE1: low bits 01,11,11,11,10,00 -> stall on the sixth cycle.
    pat6 = '{1, 1, 1, 1, 1, 0};
    rst_n = 1'b0; req = '0; wen = '0; add = '0; data = '0; be = '0;
    bd_req = 1'b0; bd_add = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Backdoor image: words 0..3 = 0x11111111..0x44444444, rest zero.
    for (int w = 0; w < MW; w++) begin
      bd_req = 1'b1; bd_add = 32'(w * 4);
      bd_data = (w < 4) ? 32'(w + 1) * 32'h11111111 : 32'h0;
      nxt();
    end
    bd_req = 1'b0;

    // Four parallel reads on four banks.
    req = 4'hF; wen = 4'hF;
    for (int i = 0; i < MP; i++) add[i] = 32'(i * 4);
    @(negedge clk); chk("t1_gnt", 32'(gnt[0]), 32'hF);
    nxt(); req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_rvalid", 32'(rvld[0]), 32'hF);
    for (int i = 0; i < MP; i++) chk($sformatf("t1_rdata%0d", i), rdat[0][i], 32'(i + 1) * 32'h11111111);

    // Partial-byte write, then read of the same word on the next cycle.
    nxt(); req = 4'b0001; wen = 4'b0000; add = '0; add[0] = 32'h10;
    data[0] = 32'hDEADBEEF; be[0] = 4'b0101;
    @(negedge clk); chk("t2_wgnt", 32'(gnt[0]), 32'h1);
    nxt(); wen = 4'b0001;
    @(negedge clk); chk("t2_rgnt", 32'(gnt[0]), 32'h1);
    nxt(); req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t2_rvalid", 32'(rvld[0][0]), 32'h1);
    chk("t2_rdata", rdat[0][0], 32'h00AD00EF);

    // Bank conflict: ports 0 and 2 on bank 0, port 2 retries.
    nxt(); req = 4'b0101; wen = 4'hF; add = '0; add[2] = 32'h40; be = '0; data = '0;
    @(negedge clk); chk("t3_gnt", 32'(gnt[0]), 32'h1);
    nxt(); req = 4'b0100;
    @(negedge clk);
    chk("t3_retry_gnt", 32'(gnt[0]), 32'h4);
    chk("t3_conflicts", ncf[0], 32'd1);

    // Back-to-back reads on port 0, latency 3.
    for (int k = 0; k < 11; k++) begin
      nxt(); req = (k < 8) ? 4'b0001 : 4'b0000; wen = 4'hF; add = '0; add[0] = 32'(k * 4);
      @(negedge clk);
      if (k >= 3) begin
        chk($sformatf("t5_rvalid%0d", k - 3), 32'(rvld[0][0]), 32'h1);
        chk($sformatf("t5_rdata%0d", k - 3), rdat[0][0], exp5[k - 3]);
      end
    end

    // Reset with two reads in flight.
    nxt(); req = 4'b0001; add[0] = 32'h0;
    nxt(); add[0] = 32'h4;
    nxt(); rst_n = 1'b0; req = '0;
    @(negedge clk);
    chk("t6_rst_rvalid", 32'(rvld[0]), 32'h0);
    chk("t6_rst_reads", nrd[0], 32'h0);
    nxt();
    nxt(); rst_n = 1'b1; req = 4'b0001; wen = 4'hF; add[0] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t6_stall_gnt%0d", k), 32'(gnt[1][0]), 32'(pat6[k]));
      if (k == 0) begin
        chk("t6_cnt_reads", nrd[0], 32'h0);
        chk("t6_cnt_conf", ncf[0], 32'h0);
        chk("t6_rvalid_gone", 32'(rvld[0]), 32'h0);
      end
      if (k == 3) begin
        chk("t6_mem_rvalid", 32'(rvld[0][0]), 32'h1);
        chk("t6_mem_retained", rdat[0][0], 32'h11111111);
      end
      nxt();
    end
    req = '0;

    // Random traffic, addresses wrapping past the array, occasional backdoor.
    for (int n = 0; n < 1000; n++) begin
      req = 4'($urandom); wen = 4'($urandom);
      for (int i = 0; i < MP; i++) begin
        add[i]  = 32'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
        data[i] = $urandom;
        be[i]   = 4'($urandom);
      end
      bd_req  = ($urandom_range(0, 15) == 0);
      bd_add  = 32'($urandom_range(0, 127) * 4);
      bd_data = $urandom;
      nxt();
    end
    req = '0; bd_req = 1'b0;
    repeat (6) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
